// File: rtl/out_port_fifo.sv
// Output-port FIFO: first-word-fall-through circular buffer between CPU port writes and an external device.
// Optional sticky drop flag (o_overflow/i_clear_ovf) is built only when OUT_PORT_OVF_EN is defined.

package arch_defs_pkg;
   localparam int DATA_WIDTH = 8;
endpackage

module out_port_fifo #(
   parameter int DATA_WIDTH = arch_defs_pkg::DATA_WIDTH,
   parameter int DEPTH      = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_load,
   input  logic [DATA_WIDTH-1:0]      i_data_in,
   output logic                       o_full,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic [DATA_WIDTH-1:0]      o_out_data,
   output logic                       o_out_valid,
   input  logic                       i_out_ready
`ifdef OUT_PORT_OVF_EN
   ,
   output logic                       o_overflow,
   input  logic                       i_clear_ovf
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]         r_wr_ptr;
   logic [PW-1:0]         r_rd_ptr;
   logic [CW-1:0]         r_count;

   logic w_full;
   logic w_valid;
   logic w_pop;
   logic w_push;

   // Status is decoded purely from r_count, so nothing here depends on i_load.
   assign w_full  = (r_count == CW'(DEPTH));
   assign w_valid = (r_count != '0);
   assign w_pop   = w_valid & i_out_ready;
   assign w_push  = i_load & (~w_full | w_pop);

   assign o_full      = w_full;
   assign o_count     = r_count;
   assign o_out_valid = w_valid;
   // Gate the head so stale storage is never exposed after reset or drain.
   assign o_out_data  = w_valid ? r_mem[r_rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= i_data_in;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + PW'(1);
         if (w_push && !w_pop)
            r_count <= r_count + CW'(1);
         else if (w_pop && !w_push)
            r_count <= r_count - CW'(1);
      end
   end

`ifdef OUT_PORT_OVF_EN
   logic r_overflow;
   logic w_drop;

   assign w_drop     = i_load & w_full & ~w_pop;
   assign o_overflow = r_overflow;

   // A drop in the same cycle as a clear wins, so no drop is ever lost.
   always_ff @(posedge clk) begin
      if (reset)
         r_overflow <= 1'b0;
      else if (w_drop)
         r_overflow <= 1'b1;
      else if (i_clear_ovf)
         r_overflow <= 1'b0;
   end
`endif

endmodule

// File: doc/out_port_fifo.md
OUT_PORT_FIFO -- requirements
Module: out_port_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default arch_defs_pkg DATA_WIDTH (8), SHALL set the word width.
REQ-002 Parameter DEPTH, default 4, SHALL set the entry count; legal values are powers of two from 2 to 16.
REQ-003 clk  input  1  SHALL be the clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be the reset: reset, synchronous, active-high; clock clk.
REQ-005 load  input  1  SHALL be the CPU output-port write strobe.
REQ-006 data_in  input  DATA_WIDTH  SHALL carry the word sampled when load=1.
REQ-007 full  output  1  SHALL be the CPU back-pressure flag, 1 when count==DEPTH.
REQ-008 count  output  $clog2(DEPTH)+1  SHALL be the number of stored words.
REQ-009 out_data  output  DATA_WIDTH  SHALL be the head word presented to the external device.
REQ-010 out_valid  output  1  SHALL be 1 when out_data holds a valid word.
REQ-011 out_ready  input  1  SHALL be the external device's acceptance signal.
REQ-012 overflow  output  1  SHALL be the sticky drop flag; present only with OUT_PORT_OVF_EN.
REQ-013 clear_ovf  input  1  SHALL clear overflow; present only with OUT_PORT_OVF_EN.

Function
REQ-014 The block SHALL be a first-word-fall-through circular FIFO with read and write pointers that wrap modulo DEPTH.
REQ-015 Push SHALL occur when load=1 and (full=0 or a pop occurs in the same cycle).
REQ-016 Pop SHALL occur when out_valid=1 and out_ready=1.
REQ-017 out_valid SHALL equal (count!=0), and out_data SHALL be all-zero whenever out_valid=0.
REQ-018 A pushed word SHALL appear on out_data one cycle after the push when the FIFO was empty; there is no bypass.
REQ-019 count SHALL change as follows: push only +1, pop only -1, push and pop together unchanged.
REQ-020 When full, push and pop occur together, the write SHALL be accepted, full SHALL stay 1, and the head SHALL advance.
REQ-021 When empty, load=1 and out_ready=1 occur together, the word SHALL be stored and no pop SHALL occur.
REQ-022 When load=1, full=1 and no pop occurs, the word SHALL be discarded and storage SHALL be unchanged.
REQ-023 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 full, count and out_valid SHALL be registered or derived only from registered state, with no combinational path from load.

Reset
REQ-025 While reset=1, pointers and count SHALL clear to 0, full=0, out_valid=0 and out_data=0, and overflow SHALL clear to 0 when present.
REQ-026 Reset SHALL take priority over load, out_ready and clear_ovf in the same cycle.
REQ-027 Storage array contents SHALL NOT be reset, and stale data SHALL never be visible on out_data.
REQ-028 Reset asserted mid-operation SHALL discard all words, and the first word after reset SHALL be the first one pushed after reset.

Configuration
REQ-029 With OUT_PORT_OVF_EN defined, overflow SHALL set on the cycle after a discarded write (REQ-022).
REQ-030 With OUT_PORT_OVF_EN defined, overflow SHALL hold until clear_ovf=1 or reset, and set takes priority over clear in the same cycle.
REQ-031 Without OUT_PORT_OVF_EN, the overflow and clear_ovf ports and their logic SHALL be absent, and discarded writes SHALL be silently dropped.

Verification
REQ-032 Reset, then load 0xA5 with out_ready=0 -> next cycle out_valid=1, out_data=0xA5, count=1, and out_data holds 0xA5 for 10 cycles.
REQ-033 Push 0x01..0x04 with out_ready=0 -> full=1, count=4; a 5th load of 0xFF is dropped; draining returns 0x01,0x02,0x03,0x04, then out_valid=0 and out_data=0x00.
REQ-034 Full FIFO with load=1 (0x55) and out_ready=1 in one cycle -> count stays 4, the head advances, and 0x55 exits last.
REQ-035 Continuous load and out_ready=1 for 20 words 0x10..0x23 -> output sequence matches input in order, including across pointer wrap, and count never exceeds 1.
REQ-036 Three words stored, then reset -> next cycle count=0, out_valid=0; push 0x77 -> out_data=0x77 one cycle later.
REQ-037 With OUT_PORT_OVF_EN, a dropped write sets overflow, which stays set through drain; clear_ovf=1 clears it; set and clear in the same cycle leaves overflow=1.
